// File: rtl/wash_pkg.sv
// wash_pkg: state encoding and sizing helpers shared by the wash controller
package wash_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_SHUTDOWN = 3'd0,
    S_BEGIN    = 3'd1,
    S_SET      = 3'd2,
    S_RUN      = 3'd3,
    S_ERROR    = 3'd4,
    S_PAUSE    = 3'd5,
    S_FINISH   = 3'd6,
    S_SLEEP    = 3'd7
  } state_t;
  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wash_tick_counter.sv
// wash_tick_counter: loadable down-counter stepping on tick unless held, saturating at zero
module wash_tick_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (tick && !hold && count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign zero = count_q == '0;
endmodule

// File: rtl/wash_program_controller.sv
// wash_program_controller: washing-machine program sequencer; define WASH_IDLE_SHUTDOWN_EN for SET/PAUSE idle shutdown
module wash_program_controller
  import wash_pkg::*;
#(
  parameter int PHASES       = 3,
  parameter int TIME_W       = 6,
  parameter int INIT_TICKS   = 2,
  parameter int FINISH_TICKS = 5,
  parameter int SLEEP_TICKS  = 10,
  parameter int IDLE_TICKS   = 30
) (
  input  logic                         cp,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         powerBtn,
  input  logic                         runBtn,
  input  logic                         openBtn,
  input  logic                         selBtn,
  input  logic [PHASES*TIME_W-1:0]     phaseTime,
  output logic [2:0]                   state,
  output logic [phase_w(PHASES)-1:0]   phase,
  output logic [TIME_W-1:0]            remaining,
  output logic [PHASES-1:0]            progMask,
  output logic                         errorFlag,
  output logic                         done
);
  localparam int PW = phase_w(PHASES);
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, first_idx, next_idx;
  logic [PHASES-1:0] mask_q, mask_d;
  logic done_q, done_d, first_ok, next_ok, clr, idle_exp;
  logic ph_load, ph_hold, ph_zero, sl_load, sl_hold, sl_zero;
  logic [TIME_W-1:0] ph_val, ph_cnt, sl_cnt;
  wire ph_last = ph_zero || ph_cnt == TIME_W'(1);
  wire sl_last = sl_zero || sl_cnt == TIME_W'(1);
  wash_tick_counter #(.W(TIME_W)) u_phase_tmr (
    .clk(cp), .rst(reset), .load(ph_load), .load_val(ph_val), .tick(tick), .hold(ph_hold),
    .count(ph_cnt), .zero(ph_zero)
  );
  wash_tick_counter #(.W(TIME_W)) u_sleep_tmr (
    .clk(cp), .rst(reset), .load(sl_load), .load_val(TIME_W'(SLEEP_TICKS)), .tick(tick), .hold(sl_hold),
    .count(sl_cnt), .zero(sl_zero)
  );
`ifdef WASH_IDLE_SHUTDOWN_EN
  logic id_load, id_zero, run_prev_q;
  logic [TIME_W-1:0] id_cnt;
  wire in_idle = state_q == S_SET || state_q == S_PAUSE;
  assign id_load = !in_idle || selBtn || runBtn != run_prev_q;
  assign idle_exp = tick && !id_load && (id_zero || id_cnt == TIME_W'(1));
  wash_tick_counter #(.W(TIME_W)) u_idle_tmr (
    .clk(cp), .rst(reset), .load(id_load), .load_val(TIME_W'(IDLE_TICKS)), .tick(tick), .hold(1'b0),
    .count(id_cnt), .zero(id_zero)
  );
  always_ff @(posedge cp or posedge reset)
    if (reset) run_prev_q <= 1'b0;
    else run_prev_q <= runBtn;
`else
  assign idle_exp = 1'b0;
`endif
  // Downward scan so the lowest qualifying index wins; next_* only considers phases above the current one.
  always_comb begin
    first_ok = 1'b0;
    first_idx = '0;
    next_ok = 1'b0;
    next_idx = '0;
    for (int i = PHASES - 1; i >= 0; i--) begin
      if (mask_q[i] && phaseTime[i*TIME_W +: TIME_W] != '0) begin
        first_ok = 1'b1;
        first_idx = PW'(i);
        if (i > int'(phase_q)) begin
          next_ok = 1'b1;
          next_idx = PW'(i);
        end
      end
    end
  end
  always_ff @(posedge cp or posedge reset)
    if (reset) begin
      state_q <= S_SHUTDOWN;
      phase_q <= '0;
      mask_q <= '1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q <= mask_d;
      done_q <= done_d;
    end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mask_d = mask_q;
    done_d = 1'b0;
    clr = 1'b0;
    ph_load = 1'b0;
    ph_val = '0;
    ph_hold = 1'b1;
    sl_load = 1'b0;
    sl_hold = 1'b1;
    case (state_q)
      S_SHUTDOWN: if (powerBtn) begin
        state_d = S_BEGIN;
        ph_load = 1'b1;
        ph_val = TIME_W'(INIT_TICKS);
      end
      S_BEGIN: if (powerBtn) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end else begin
        ph_hold = 1'b0;
        if (tick && ph_last) state_d = S_SET;
      end
      S_SET: if (powerBtn) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end else if (runBtn && !openBtn) begin
        state_d = first_ok ? S_RUN : S_FINISH;
        done_d = !first_ok;
        phase_d = first_ok ? first_idx : '0;
        ph_load = 1'b1;
        ph_val = first_ok ? phaseTime[first_idx*TIME_W +: TIME_W] : TIME_W'(FINISH_TICKS);
      end else if (selBtn) mask_d = &mask_q ? PHASES'(1) : mask_q + 1'b1;
      else if (idle_exp) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end
      S_RUN: if (powerBtn) begin
        state_d = S_SLEEP;
        sl_load = 1'b1;
      end else if (openBtn) state_d = (phase_q == PW'(PHASES - 1)) ? S_ERROR : S_PAUSE;
      else if (!runBtn) state_d = S_PAUSE;
      else if (tick && ph_last) begin
        state_d = next_ok ? S_RUN : S_FINISH;
        done_d = !next_ok;
        phase_d = next_ok ? next_idx : phase_q;
        ph_load = 1'b1;
        ph_val = next_ok ? phaseTime[next_idx*TIME_W +: TIME_W] : TIME_W'(FINISH_TICKS);
      end else ph_hold = 1'b0;
      S_ERROR: if (powerBtn) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end else if (!openBtn) state_d = S_RUN;
      S_PAUSE: if (powerBtn || (!(runBtn && !openBtn) && (selBtn || idle_exp))) begin
        state_d = (powerBtn || !selBtn) ? S_SHUTDOWN : S_SET;
        clr = 1'b1;
      end else if (runBtn && !openBtn) state_d = S_RUN;
      S_FINISH: if (powerBtn || (runBtn && tick && ph_last)) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end else if (!runBtn) begin
        state_d = S_SET;
        clr = 1'b1;
      end else ph_hold = 1'b0;
      S_SLEEP: if (powerBtn) state_d = S_RUN;
      else if (tick && sl_last) begin
        state_d = S_SHUTDOWN;
        clr = 1'b1;
      end else sl_hold = 1'b0;
      default: state_d = S_SHUTDOWN;
    endcase
    if (clr) begin
      ph_load = 1'b1;
      ph_val = '0;
      phase_d = '0;
    end
  end
  always_comb begin
    state = state_q;
    phase = phase_q;
    progMask = mask_q;
    done = done_q;
    errorFlag = state_q == S_ERROR;
    remaining = (state_q == S_SLEEP) ? sl_cnt : ph_cnt;
  end
endmodule

// File: tb/tb_wash_program_controller.sv
// tb_wash_program_controller: directed checks of the wash controller with hand-computed expectations
module tb_wash_program_controller;
  logic cp = 1'b0, reset = 1'b1, tick = 1'b0, powerBtn = 1'b0, runBtn = 1'b0, openBtn = 1'b0, selBtn = 1'b0;
  logic [17:0] phaseTime = '0;
  logic [2:0] state, progMask;
  logic [1:0] phase;
  logic [5:0] remaining;
  logic errorFlag, done;
  int checks = 0, errors = 0;
  wash_program_controller dut (
    .cp(cp), .reset(reset), .tick(tick), .powerBtn(powerBtn), .runBtn(runBtn), .openBtn(openBtn),
    .selBtn(selBtn), .phaseTime(phaseTime), .state(state), .phase(phase), .remaining(remaining),
    .progMask(progMask), .errorFlag(errorFlag), .done(done)
  );
  always #5 cp = ~cp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge cp);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask
  task automatic power();
    powerBtn = 1'b1;
    step();
    powerBtn = 1'b0;
  endtask
  task automatic sel(input int n);
    for (int i = 0; i < n; i++) begin
      selBtn = 1'b1;
      step();
      selBtn = 1'b0;
    end
  endtask
  task automatic expect_spr(input string tag, input int s, input int ph, input int rem);
    check({tag, "_state"}, 32'(state), 32'(s));
    check({tag, "_phase"}, 32'(phase), 32'(ph));
    check({tag, "_rem"}, 32'(remaining), 32'(rem));
  endtask
  initial begin
    step();
    step();
    expect_spr("reset", 0, 0, 0);
    check("reset_mask", 32'(progMask), 7);
    check("reset_err", 32'(errorFlag), 0);
    check("reset_done", 32'(done), 0);
    reset = 1'b0;
    power();
    expect_spr("begin", 1, 0, 2);
    ticks(1);
    expect_spr("begin_t1", 1, 0, 1);
    ticks(1);
    expect_spr("set", 2, 0, 0);
    check("set_mask", 32'(progMask), 7);
    phaseTime = {6'd3, 6'd2, 6'd4};
    runBtn = 1'b1;
    step();
    expect_spr("run0", 3, 0, 4);
    ticks(3);
    expect_spr("run0_end", 3, 0, 1);
    ticks(1);
    expect_spr("run1", 3, 1, 2);
    ticks(2);
    expect_spr("run2", 3, 2, 3);
    ticks(2);
    check("run2_rem", 32'(remaining), 1);
    check("run_done_early", 32'(done), 0);
    ticks(1);
    expect_spr("finish", 6, 2, 5);
    check("finish_done", 32'(done), 1);
    step();
    check("done_pulse_end", 32'(done), 0);
    ticks(4);
    expect_spr("finish_t4", 6, 2, 1);
    ticks(1);
    expect_spr("auto_off", 0, 0, 0);
    runBtn = 1'b0;
    power();
    ticks(2);
    check("set2_state", 32'(state), 2);
    sel(3);
    check("mask_wrap", 32'(progMask), 3);
    runBtn = 1'b1;
    step();
    expect_spr("m_run0", 3, 0, 4);
    ticks(4);
    expect_spr("m_run1", 3, 1, 2);
    ticks(2);
    expect_spr("m_finish", 6, 1, 5);
    check("m_done", 32'(done), 1);
    runBtn = 1'b0;
    step();
    expect_spr("fin_to_set", 2, 0, 0);
    check("mask_kept", 32'(progMask), 3);
    sel(4);
    check("mask_full", 32'(progMask), 7);
    runBtn = 1'b1;
    step();
    ticks(5);
    expect_spr("d_run1", 3, 1, 1);
    openBtn = 1'b1;
    step();
    expect_spr("pause", 5, 1, 1);
    ticks(2);
    expect_spr("pause_frozen", 5, 1, 1);
    openBtn = 1'b0;
    step();
    expect_spr("resume", 3, 1, 1);
    ticks(1);
    expect_spr("spin", 3, 2, 3);
    ticks(1);
    openBtn = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    expect_spr("error", 4, 2, 2);
    check("error_flag", 32'(errorFlag), 1);
    ticks(1);
    check("error_frozen", 32'(remaining), 2);
    openBtn = 1'b0;
    step();
    expect_spr("err_resume", 3, 2, 2);
    check("err_clear", 32'(errorFlag), 0);
    powerBtn = 1'b1;
    tick = 1'b1;
    step();
    powerBtn = 1'b0;
    tick = 1'b0;
    expect_spr("sleep", 7, 2, 10);
    power();
    expect_spr("wake", 3, 2, 2);
    power();
    ticks(9);
    expect_spr("sleep_t9", 7, 2, 1);
    ticks(1);
    expect_spr("sleep_off", 0, 0, 0);
    phaseTime = '0;
    runBtn = 1'b0;
    power();
    ticks(2);
    runBtn = 1'b1;
    step();
    expect_spr("empty_fin", 6, 0, 5);
    check("empty_done", 32'(done), 1);
    runBtn = 1'b0;
    step();
    expect_spr("empty_set", 2, 0, 0);
    phaseTime = {6'd3, 6'd2, 6'd4};
    runBtn = 1'b1;
    step();
    ticks(1);
    expect_spr("p_run", 3, 0, 3);
    runBtn = 1'b0;
    step();
    expect_spr("p_pause", 5, 0, 3);
    sel(1);
    expect_spr("p_set", 2, 0, 0);
    check("p_mask", 32'(progMask), 7);
    sel(1);
    check("mask_one", 32'(progMask), 1);
    runBtn = 1'b1;
    step();
    ticks(1);
    expect_spr("a_run", 3, 0, 3);
    #2 reset = 1'b1;
    #1;
    expect_spr("async", 0, 0, 0);
    check("async_mask", 32'(progMask), 7);
    step();
    reset = 1'b0;
    runBtn = 1'b0;
    step();
    check("post_reset", 32'(state), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
